// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (PC + instruction memory), the fetch queue and decode.
// The master drives the fetch pair and decode acceptance; the slave is the queue itself.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
);
    logic [31:0]             pc_addr;
    logic [31:0]             instr_in;
    logic                    fetch_valid;
    logic                    fetch_ready;
    logic                    dec_ready;
    logic                    dec_valid;
    logic [31:0]             dec_instr;
    logic [31:0]             dec_pc;
    logic [31:0]             dec_pc_plus4;
    logic                    flush;
    logic [$clog2(DEPTH):0]  count;

    modport master (
        output pc_addr, instr_in, fetch_valid, dec_ready, flush,
        input  fetch_ready, dec_valid, dec_instr, dec_pc, dec_pc_plus4, count
    );

    modport slave (
        input  pc_addr, instr_in, fetch_valid, dec_ready, flush,
        output fetch_ready, dec_valid, dec_instr, dec_pc, dec_pc_plus4, count
    );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through queue of {PC, instruction} pairs between fetch and decode.
// Fetch_Ready gates the PC enable; Flush drops all wrong-path entries.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    entry_t        head;
    logic [31:0]   dec_pc;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Ready depends only on registered occupancy and reset, never on Dec_Ready or Flush.
    assign bus.fetch_ready = rst_n && !full;

    assign push = bus.fetch_valid && bus.fetch_ready && !bus.flush;
    assign pop  = !empty && bus.dec_ready && !bus.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is reset here because reset must leave every entry at zero; it is a small
    // flop array, not a RAM macro, so the reset costs nothing structurally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{pc: bus.pc_addr, instr: bus.instr_in};
        end
    end

    // Head is read combinationally; an empty queue presents a NOP at address 0.
    assign head              = mem_q[rd_ptr_q];
    assign dec_pc            = empty ? 32'h0 : head.pc;
    assign bus.dec_valid     = !empty;
    assign bus.dec_instr     = empty ? NOP_WORD : head.instr;
    assign bus.dec_pc        = dec_pc;
    assign bus.dec_pc_plus4  = dec_pc + 32'd4;
    assign bus.count         = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a vector table for the steady-state behaviour plus
// hand-written sequences for reset entry/exit and asynchronous reset mid-operation.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;

    logic clk;
    logic rst_n;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        fv;
        logic        dr;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        e_fr;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic flush, input logic fv, input logic dr,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic e_fr, input logic e_dv, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [2:0] e_cnt);
        vec_t v;
        v.flush = flush; v.fv = fv; v.dr = dr; v.pc = pc; v.instr = instr;
        v.e_fr = e_fr; v.e_dv = e_dv; v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic drive(input logic flush, input logic fv, input logic dr,
                         input logic [31:0] pc, input logic [31:0] instr);
        bus.flush       = flush;
        bus.fetch_valid = fv;
        bus.dec_ready   = dr;
        bus.pc_addr     = pc;
        bus.instr_in    = instr;
    endtask

    task automatic check_outputs(input string tag, input logic e_fr, input logic e_dv,
                                 input logic [31:0] e_pc, input logic [31:0] e_instr,
                                 input logic [2:0] e_cnt);
        check({tag, ".fetch_ready"}, 32'(bus.fetch_ready), 32'(e_fr));
        check({tag, ".dec_valid"},   32'(bus.dec_valid),   32'(e_dv));
        check({tag, ".dec_pc"},      bus.dec_pc,           e_pc);
        check({tag, ".dec_instr"},   bus.dec_instr,        e_instr);
        check({tag, ".dec_pc_plus4"}, bus.dec_pc_plus4,    e_pc + 32'd4);
        check({tag, ".count"},       32'(bus.count),       32'(e_cnt));
    endtask

    initial begin
        logic [31:0] p;

        // Empty / full / wrap / flush scenarios; each entry is checked just after its edge.
        vecs.push_back(mk(0, 1, 0, 32'h0, 32'h2008_0005, 1, 1, 32'h0, 32'h2008_0005, 3'd1));
        for (int k = 1; k <= 3; k++) begin
            p = 32'(k * 4);
            vecs.push_back(mk(0, 1, 0, p, 32'h1000_0000 | p, (k < 3), 1, 32'h0, 32'h2008_0005,
                              3'(k + 1)));
        end
        vecs.push_back(mk(0, 1, 0, 32'h10, 32'h1000_0010, 0, 1, 32'h0, 32'h2008_0005, 3'd4));
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h4, 32'h1000_0004, 3'd3));
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 1, 32'h8, 32'h1000_0008, 3'd2));
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 1, 32'hC, 32'h1000_000C, 3'd1));
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 3'd0));
        for (int k = 0; k < 12; k++) begin
            p = 32'(k * 4);
            vecs.push_back(mk(0, 1, 1, p, 32'hA500_0000 | p, 1, 1, p, 32'hA500_0000 | p, 3'd1));
        end
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 3'd0));
        for (int k = 0; k < 3; k++) begin
            p = 32'h100 + 32'(k * 4);
            vecs.push_back(mk(0, 1, 0, p, 32'hB000_0000 | p, 1, 1, 32'h100, 32'hB000_0100,
                              3'(k + 1)));
        end
        vecs.push_back(mk(1, 1, 1, 32'h200, 32'hB000_0200, 1, 0, 32'h0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 3'd0));
        vecs.push_back(mk(0, 1, 0, 32'h300, 32'hB000_0300, 1, 1, 32'h300, 32'hB000_0300, 3'd1));
        vecs.push_back(mk(0, 0, 1, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0, 3'd0));

        // Reset held for three edges, then released.
        rst_n = 1'b0;
        drive(0, 1, 1, 32'h40, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check_outputs($sformatf("reset%0d", c), 0, 0, 32'h0, 32'h0, 3'd0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check_outputs("release", 1, 0, 32'h0, 32'h0, 3'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].fv, vecs[i].dr, vecs[i].pc, vecs[i].instr);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_fr, vecs[i].e_dv, vecs[i].e_pc,
                          vecs[i].e_instr, vecs[i].e_cnt);
        end

        // Asynchronous reset between edges with two entries queued.
        drive(0, 1, 0, 32'h400, 32'hC000_0400);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 32'h404, 32'hC000_0404);
        @(posedge clk);
        #1;
        check_outputs("pre_async", 1, 1, 32'h400, 32'hC000_0400, 3'd2);
        drive(0, 1, 1, 32'h408, 32'hC000_0408);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 32'h0, 32'h0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 1, 0, 32'hFFFF_FFFC, 32'h1234_5678);
        @(posedge clk);
        #1;
        check_outputs("wrap_pc", 1, 1, 32'hFFFF_FFFC, 32'h1234_5678, 3'd1);
        check("wrap_plus4_zero", bus.dec_pc_plus4, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
